shift_pipe: RTL and testbench
=============================

Name: shift_pipe

Overview:
- Parametrised multi-bit shift register: DEPTH stages, each WIDTH bits wide.
- Modes: hold, serial shift (either direction), parallel load, rotate.
- Selectable tap output and a fill-status flag.
- Sits in the clocked-datapath library as the general replacement for fixed 8-stage single-bit delay chains; drives delay lines, serialisers and pattern generators.

Parameters:
- WIDTH, 1, bits per stage.
- DEPTH, 8, number of stages; legal range 2..256.
- SEL_W, $clog2(DEPTH), width of tap_sel; derived, never overridden.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  operation enable; 0 = all state holds regardless of mode.
- mode  in  2  00 hold, 01 shift, 10 parallel load, 11 rotate.
- dir  in  1  0 = toward higher stage index (stage0 is input), 1 = toward lower index (stage DEPTH-1 is input).
- sin  in  WIDTH  serial input word.
- pload  in  WIDTH*DEPTH  parallel load data; stage i = pload[i*WIDTH +: WIDTH].
- tap_sel  in  SEL_W  stage index driven onto tap.
- sout  out  WIDTH  serial output: stage DEPTH-1 when dir=0, stage0 when dir=1 (combinational mux on dir).
- tap  out  WIDTH  stage[tap_sel]; 0 when tap_sel >= DEPTH.
- pout  out  WIDTH*DEPTH  all stages, same packing as pload.
- full  out  1  1 when fill count == DEPTH.

Behaviour:
- Reset: asserting reset_n low immediately clears all stages to 0 and the fill count to 0. While reset is held: sout=0, pout=0, full=0, tap=0. Reset mid-operation discards everything. First update happens on the first rising edge after reset_n deasserts.
- All state updates on the rising clock edge only when en=1. en=0 freezes stages and fill count.
- Hold (00): no change.
- Shift (01), dir=0: stage0 <= sin; stage[i] <= stage[i-1] for i = 1..DEPTH-1. Old stage DEPTH-1 is dropped.
- Shift (01), dir=1: stage[DEPTH-1] <= sin; stage[i] <= stage[i+1]. Old stage0 is dropped.
- Latency: sin appears on sout exactly DEPTH enabled shift edges later (same dir throughout).
- Load (10): every stage <= its pload slice in one edge; fill count <= DEPTH.
- Rotate (11), dir=0: stage0 <= stage[DEPTH-1], others as shift; sin ignored.
- Rotate (11), dir=1: stage[DEPTH-1] <= stage0, others as shift; sin ignored.
- Rotate never changes the fill count and is lossless; DEPTH rotates restore the original contents.
- Fill count: width $clog2(DEPTH+1).
  - Increments by 1 on each enabled shift and saturates at DEPTH; no wrap.
  - Unaffected by a dir change.
- full is registered state decoded combinationally from the count. It rises in the cycle after the DEPTH-th shift edge, or after a load edge.
- A mode change between cycles takes effect on the next edge with no bubble. A dir change mid-stream is legal: data already present is simply moved the other way.
- tap, sout and pout are combinational from stage registers and the dir/tap_sel inputs only. No input-to-output path through sin or pload.

Optional Feature:
- Macro: SHIFT_PIPE_COUNT_SRC_EN.
- Defined:
  - Adds an internal 4-bit free-running counter, reset to 0 by reset_n.
  - Counter increments on every clock edge, independent of en.
  - The serial input word becomes {WIDTH{count[3]}}; port sin stays present but is ignored.
  - This produces a square wave of period 16 clocks entering the chain.
- Not defined: no counter; serial input is sin.

Test Plan:
- Reset check: reset_n=0 asynchronously mid-shift with stages nonzero -> pout=0, full=0, sout=0 before the next clock edge.
- Shift latency: WIDTH=1, DEPTH=8, dir=0, en=1, mode=01, sin=1 for one edge then 0 -> sout=1 exactly 8 edges later for one cycle; full=1 after the 8th edge and stays 1.
- Load and rotate: WIDTH=4, DEPTH=4, pload=16'h4321, mode=10 -> pout=16'h4321, full=1.
  - Then 1 rotate with dir=0 -> pout=16'h3214.
  - Then 4 rotates with dir=1 -> pout=16'h3214.
- Reverse shift and tap: after load 16'h4321, dir=1 shift with sin=4'hA -> pout=16'hA432.
  - tap_sel=3 -> tap=4'hA; tap_sel=0 -> tap=4'h2.
- Enable gating: during shift, en=0 for 5 cycles with sin toggling -> pout and fill count unchanged; resuming en=1 continues from the frozen state.
- Optional feature: with SHIFT_PIPE_COUNT_SRC_EN, WIDTH=1, DEPTH=8, mode=01, dir=0 continuously from reset -> sout is 0 through the 16th edge after reset release, then alternates 8 ones / 8 zeros (first 1 after the 16th edge).

Source files
------------

// File: rtl/shift_pipe.sv
// shift_pipe: parametrised WIDTH x DEPTH shift register with hold/shift/load/rotate.
// Optional macro SHIFT_PIPE_COUNT_SRC_EN feeds a 16-clock square wave in place of sin.
module shift_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8,
  localparam int SEL_W = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic                   dir,
  input  logic [WIDTH-1:0]       sin,
  input  logic [WIDTH*DEPTH-1:0] pload,
  input  logic [SEL_W-1:0]       tap_sel,
  output logic [WIDTH-1:0]       sout,
  output logic [WIDTH-1:0]       tap,
  output logic [WIDTH*DEPTH-1:0] pout,
  output logic                   full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FILL_MAX = CW'(DEPTH);

  localparam logic [1:0] M_HOLD  = 2'b00;
  localparam logic [1:0] M_SHIFT = 2'b01;
  localparam logic [1:0] M_LOAD  = 2'b10;
  localparam logic [1:0] M_ROT   = 2'b11;

  logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
  logic [CW-1:0]               fill_q, fill_d;
  logic [WIDTH-1:0]            ser_in;

`ifdef SHIFT_PIPE_COUNT_SRC_EN
  logic [3:0] src_cnt_q, src_cnt_d;
  logic       unused_sin;

  assign unused_sin = ^sin;

  // free-running source counter, ignores en
  always_comb begin
    src_cnt_d = src_cnt_q + 4'd1;
  end

  // source counter register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) src_cnt_q <= '0;
    else          src_cnt_q <= src_cnt_d;
  end

  assign ser_in = {WIDTH{src_cnt_q[3]}};
`else
  assign ser_in = sin;
`endif

  // next-state for stages and fill count
  always_comb begin
    stage_d = stage_q;
    fill_d  = fill_q;
    if (en) begin
      unique case (mode)
        M_HOLD: ;
        M_SHIFT: begin
          if (!dir) begin
            stage_d[0] = ser_in;
            for (int i = 1; i < DEPTH; i++)
              stage_d[i] = stage_q[i-1];
          end else begin
            stage_d[DEPTH-1] = ser_in;
            for (int i = 0; i < DEPTH-1; i++)
              stage_d[i] = stage_q[i+1];
          end
          if (fill_q != FILL_MAX)
            fill_d = fill_q + CW'(1);
        end
        M_LOAD: begin
          stage_d = pload;
          fill_d  = FILL_MAX;
        end
        M_ROT: begin
          if (!dir) begin
            stage_d[0] = stage_q[DEPTH-1];
            for (int i = 1; i < DEPTH; i++)
              stage_d[i] = stage_q[i-1];
          end else begin
            stage_d[DEPTH-1] = stage_q[0];
            for (int i = 0; i < DEPTH-1; i++)
              stage_d[i] = stage_q[i+1];
          end
        end
        default: ;
      endcase
    end
  end

  // stage and fill registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= '0;
      fill_q  <= '0;
    end else begin
      stage_q <= stage_d;
      fill_q  <= fill_d;
    end
  end

  // tap mux, zero for out-of-range selects
  always_comb begin
    tap = '0;
    if (int'(tap_sel) < DEPTH)
      tap = stage_q[tap_sel];
  end

  assign sout = dir ? stage_q[0] : stage_q[DEPTH-1];
  assign pout = stage_q;
  assign full = (fill_q == FILL_MAX);

endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: directed table plus hand sequences for shift_pipe.
// Three instances: 1x8, 4x4 and 2x3 (non power-of-two depth).
module tb_shift_pipe;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  int n_err = 0;
  int n_chk = 0;

  // u1: WIDTH=1 DEPTH=8
  logic       en1 = 0;
  logic [1:0] mode1 = 0;
  logic       dir1 = 0;
  logic [0:0] sin1 = 0;
  logic [7:0] pl1 = 0;
  logic [2:0] ts1 = 0;
  logic [0:0] so1, tp1;
  logic [7:0] po1;
  logic       fu1;

  // u4: WIDTH=4 DEPTH=4
  logic        en4 = 0;
  logic [1:0]  mode4 = 0;
  logic        dir4 = 0;
  logic [3:0]  sin4 = 0;
  logic [15:0] pl4 = 0;
  logic [1:0]  ts4 = 0;
  logic [3:0]  so4, tp4;
  logic [15:0] po4;
  logic        fu4;

  // u3: WIDTH=2 DEPTH=3
  logic       en3 = 0;
  logic [1:0] mode3 = 0;
  logic       dir3 = 0;
  logic [1:0] sin3 = 0;
  logic [5:0] pl3 = 0;
  logic [1:0] ts3 = 0;
  logic [1:0] so3, tp3;
  logic [5:0] po3;
  logic       fu3;

  shift_pipe #(.WIDTH(1), .DEPTH(8)) u1 (
    .clock(clock), .reset_n(reset_n), .en(en1), .mode(mode1),
    .dir(dir1), .sin(sin1), .pload(pl1), .tap_sel(ts1),
    .sout(so1), .tap(tp1), .pout(po1), .full(fu1)
  );

  shift_pipe #(.WIDTH(4), .DEPTH(4)) u4 (
    .clock(clock), .reset_n(reset_n), .en(en4), .mode(mode4),
    .dir(dir4), .sin(sin4), .pload(pl4), .tap_sel(ts4),
    .sout(so4), .tap(tp4), .pout(po4), .full(fu4)
  );

  shift_pipe #(.WIDTH(2), .DEPTH(3)) u3 (
    .clock(clock), .reset_n(reset_n), .en(en3), .mode(mode3),
    .dir(dir3), .sin(sin3), .pload(pl3), .tap_sel(ts3),
    .sout(so3), .tap(tp3), .pout(po3), .full(fu3)
  );

  typedef struct {
    string       name;
    logic        en;
    logic [1:0]  mode;
    logic        dir;
    logic [3:0]  sin;
    logic [15:0] pload;
    logic [1:0]  tsel;
    logic [15:0] e_pout;
    logic [3:0]  e_tap;
    logic        e_full;
    logic [3:0]  e_sout;
  } vec_t;

  vec_t v[12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    v[0]  = '{"load",     1, 2'b10, 0, 4'h0, 16'h4321, 2'd0, 16'h4321, 4'h1, 1, 4'h4};
    v[1]  = '{"rot_d0",   1, 2'b11, 0, 4'h0, 16'h0000, 2'd0, 16'h3214, 4'h4, 1, 4'h3};
    v[2]  = '{"rot_d1_1", 1, 2'b11, 1, 4'hF, 16'h0000, 2'd3, 16'h4321, 4'h4, 1, 4'h1};
    v[3]  = '{"rot_d1_2", 1, 2'b11, 1, 4'hF, 16'h0000, 2'd3, 16'h1432, 4'h1, 1, 4'h2};
    v[4]  = '{"rot_d1_3", 1, 2'b11, 1, 4'hF, 16'h0000, 2'd3, 16'h2143, 4'h2, 1, 4'h3};
    v[5]  = '{"rot_d1_4", 1, 2'b11, 1, 4'hF, 16'h0000, 2'd3, 16'h3214, 4'h3, 1, 4'h4};
    v[6]  = '{"reload",   1, 2'b10, 0, 4'h0, 16'h4321, 2'd0, 16'h4321, 4'h1, 1, 4'h4};
    v[7]  = '{"shift_d1", 1, 2'b01, 1, 4'hA, 16'h0000, 2'd3, 16'hA432, 4'hA, 1, 4'h2};
    v[8]  = '{"hold",     1, 2'b00, 1, 4'h7, 16'hFFFF, 2'd0, 16'hA432, 4'h2, 1, 4'h2};
    v[9]  = '{"en0_shift",0, 2'b01, 1, 4'h5, 16'h0000, 2'd0, 16'hA432, 4'h2, 1, 4'h2};
    v[10] = '{"shift_d0", 1, 2'b01, 0, 4'h5, 16'h0000, 2'd1, 16'h4325, 4'h2, 1, 4'h4};
    v[11] = '{"en0_load", 0, 2'b10, 1, 4'h0, 16'h0000, 2'd2, 16'h4325, 4'h3, 1, 4'h5};

`ifdef SHIFT_PIPE_COUNT_SRC_EN
    en1 = 1; mode1 = 2'b01; dir1 = 0;
`endif
    repeat (2) @(posedge clock);
    #1;
    chk("rst_pout4", 32'(po4), 32'h0);
    chk("rst_full4", 32'(fu4), 32'h0);
    chk("rst_sout4", 32'(so4), 32'h0);
    chk("rst_tap4",  32'(tp4), 32'h0);
    reset_n = 1'b1;

`ifdef SHIFT_PIPE_COUNT_SRC_EN
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk($sformatf("cnt_sout_e%0d", k), 32'(so1),
          (k >= 16) ? 32'((((k - 16) / 8) % 2) == 0) : 32'h0);
    end
`else
    // table on u4
    for (int i = 0; i < 12; i++) begin
      en4 = v[i].en; mode4 = v[i].mode; dir4 = v[i].dir;
      sin4 = v[i].sin; pl4 = v[i].pload; ts4 = v[i].tsel;
      tick();
      chk({v[i].name, "_pout"}, 32'(po4), 32'(v[i].e_pout));
      chk({v[i].name, "_tap"},  32'(tp4), 32'(v[i].e_tap));
      chk({v[i].name, "_full"}, 32'(fu4), 32'(v[i].e_full));
      chk({v[i].name, "_sout"}, 32'(so4), 32'(v[i].e_sout));
    end
    en4 = 0;

    // u1 latency with a 5-cycle enable gap
    en1 = 1; mode1 = 2'b01; dir1 = 0; sin1 = 1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      sin1 = 0;
      chk($sformatf("lat_pout_k%0d", k), 32'(po1), 32'(8'h01 << (k - 1)));
      chk($sformatf("lat_full_k%0d", k), 32'(fu1), 32'h0);
    end
    en1 = 0;
    for (int g = 0; g < 5; g++) begin
      sin1 = ~sin1;
      tick();
      chk($sformatf("gate_pout_%0d", g), 32'(po1), 32'h08);
      chk($sformatf("gate_full_%0d", g), 32'(fu1), 32'h0);
    end
    en1 = 1; sin1 = 0;
    for (int k = 5; k <= 10; k++) begin
      tick();
      chk($sformatf("lat_pout_k%0d", k), 32'(po1),
          (k <= 8) ? 32'(8'h01 << (k - 1)) : 32'h0);
      chk($sformatf("lat_sout_k%0d", k), 32'(so1), 32'(k == 8));
      chk($sformatf("lat_full_k%0d", k), 32'(fu1), 32'(k >= 8));
    end
    en1 = 0;

    // u3 fill saturation and out-of-range tap
    en3 = 1; mode3 = 2'b01; dir3 = 0; sin3 = 2'b11; ts3 = 2'd3;
    for (int j = 1; j <= 4; j++) begin
      tick();
      chk($sformatf("d3_full_%0d", j), 32'(fu3), 32'(j >= 3));
      chk($sformatf("d3_pout_%0d", j), 32'(po3),
          (j == 1) ? 32'h03 : (j == 2) ? 32'h0F : 32'h3F);
      chk($sformatf("d3_tap_oob_%0d", j), 32'(tp3), 32'h0);
    end
    en3 = 0; ts3 = 2'd2;
    #1;
    chk("d3_tap2", 32'(tp3), 32'h3);

    // async reset between edges
    en4 = 1; mode4 = 2'b01; dir4 = 0; sin4 = 4'h9; ts4 = 2'd2;
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_pout4", 32'(po4), 32'h0);
    chk("arst_full4", 32'(fu4), 32'h0);
    chk("arst_sout4", 32'(so4), 32'h0);
    chk("arst_tap4",  32'(tp4), 32'h0);
    chk("arst_pout3", 32'(po3), 32'h0);
    chk("arst_full3", 32'(fu3), 32'h0);
    mode4 = 2'b10; pl4 = 16'hFFFF;
    tick();
    chk("arst_hold_pout4", 32'(po4), 32'h0);
    chk("arst_hold_full4", 32'(fu4), 32'h0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_load", 32'(po4), 32'hFFFF);
    chk("post_rst_full", 32'(fu4), 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
